// File: rtl/axil_pkg.sv
// Shared AXI-Lite constants and the bridge state encoding.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_B,
      READ,
      WAIT_R,
      RESP
   } state_t;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI-Lite initiator for the core's native memory port.
// Define AXIL_TIMEOUT_EN to add a watchdog that completes stuck transactions with an error.
module axil_master_bridge
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  mem_valid,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [STRB_WIDTH-1:0] mem_wstrb,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_error,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done, w_done;
   logic                  aw_hs, w_hs;

   assign aw_hs = m_axil_awvalid && m_axil_awready;
   assign w_hs  = m_axil_wvalid && m_axil_wready;

   assign m_axil_awaddr = addr_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = wstrb_q;
   assign m_axil_awprot = PROT_DEFAULT;
   assign m_axil_arprot = PROT_DEFAULT;

`ifdef AXIL_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        busy, tmo_hit;
   assign busy    = (state == WRITE) || (state == WAIT_B) || (state == READ) || (state == WAIT_R);
   // Fires on the edge where the busy-cycle count reaches TIMEOUT_CYCLES-1.
   assign tmo_hit = busy && ((tmo_cnt + 16'd1) == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state          <= IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         m_axil_awvalid <= 1'b0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         m_axil_arvalid <= 1'b0;
         m_axil_rready  <= 1'b0;
         mem_ready      <= 1'b0;
         mem_rdata      <= '0;
         mem_error      <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
         tmo_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  addr_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  wstrb_q <= mem_wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (mem_wstrb != '0) begin
                     m_axil_awvalid <= 1'b1;
                     m_axil_wvalid  <= 1'b1;
                     state          <= WRITE;
                  end else begin
                     m_axil_arvalid <= 1'b1;
                     state          <= READ;
                  end
               end
            end
            WRITE: begin
               if (aw_hs) begin
                  m_axil_awvalid <= 1'b0;
                  aw_done        <= 1'b1;
               end
               if (w_hs) begin
                  m_axil_wvalid <= 1'b0;
                  w_done        <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  m_axil_bready <= 1'b1;
                  state         <= WAIT_B;
               end
            end
            WAIT_B: begin
               // bvalid is only honoured here; a slave may hold it high permanently.
               if (m_axil_bvalid) begin
                  m_axil_bready <= 1'b0;
                  mem_error     <= (m_axil_bresp != RESP_OKAY);
                  mem_rdata     <= '0;
                  mem_ready     <= 1'b1;
                  state         <= RESP;
               end
            end
            READ: begin
               if (m_axil_arready) begin
                  m_axil_arvalid <= 1'b0;
                  m_axil_rready  <= 1'b1;
                  state          <= WAIT_R;
               end
            end
            WAIT_R: begin
               if (m_axil_rvalid) begin
                  m_axil_rready <= 1'b0;
                  mem_error     <= (m_axil_rresp != RESP_OKAY);
                  mem_rdata     <= m_axil_rdata;
                  mem_ready     <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

`ifdef AXIL_TIMEOUT_EN
         if (state == IDLE) tmo_cnt <= '0;
         else if (busy)     tmo_cnt <= tmo_cnt + 16'd1;
         // Abandon the bus side; any late B/R is left unconsumed.
         if (tmo_hit) begin
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            mem_error      <= 1'b1;
            mem_rdata      <= '1;
            mem_ready      <= 1'b1;
            state          <= RESP;
         end
`endif
      end
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench for axil_master_bridge: per-cycle slave model, expected completions queued at issue.
module tb_axil_master_bridge;

   logic        aclk = 1'b0;
   logic        areset;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready, mem_error;
   logic [31:0] mem_rdata;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int n_chk  = 0;
   int n_pass = 0;
   logic [32:0] sb[$];

   always #5 aclk = ~aclk;

   axil_master_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
`ifdef AXIL_TIMEOUT_EN
      .TIMEOUT_CYCLES(8)
`else
      .TIMEOUT_CYCLES(1024)
`endif
   ) dut (
      .aclk(aclk), .areset(areset),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic idle_slave();
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
   endtask

   // One request; delays are cycles of ready-low after the channel opens.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int awd, input int wd, input int ard,
                       input int rd, input logic [1:0] resp, input logic [31:0] rdat,
                       input logic bhold, input int exp_lat, input bit tmo, input int rst_at);
      int aw_n, w_n, b_n, ar_n, r_n, ar_c, lat;
      bit done;
      logic [32:0] e;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; ar_c = 0; lat = 0; done = 0;
      mem_valid = 1; mem_addr = addr; mem_wdata = data; mem_wstrb = wr ? strb : 4'h0;
      if (tmo)     sb.push_back({1'b1, 32'hFFFF_FFFF});
      else if (wr) sb.push_back({resp != 2'b00, 32'h0});
      else         sb.push_back({resp != 2'b00, rdat});
      @(posedge aclk); #1;
      mem_valid = 0; mem_wstrb = 0;
      for (int c = 1; c <= 60 && !done; c++) begin
         awready = (c > awd); wready = (c > wd); arready = (c > ard);
         bvalid  = bhold || (aw_n > 0 && w_n > 0 && b_n == 0);
         rvalid  = (ar_n > 0 && r_n == 0 && c >= ar_c + 1 + rd);
         bresp = resp; rresp = resp; rdata = rdat;
         if (c == rst_at) begin
            areset = 1; #1;
            chk("rst_rready", rready, 0);
            chk("rst_arvalid", arvalid, 0);
            chk("rst_mem_ready", mem_ready, 0);
            chk("rst_rdata", mem_rdata, 0);
            areset = 0;
            void'(sb.pop_front());
            idle_slave();
            @(posedge aclk); #1;
            return;
         end
         if (awvalid) begin
            chk("awaddr", awaddr, addr);
            chk("awprot", awprot, 0);
         end
         if (wvalid) begin
            chk("wdata", wdata, data);
            chk("wstrb", wstrb, strb);
         end
         if (arvalid) begin
            chk("araddr", araddr, addr);
            chk("arprot", arprot, 0);
         end
         chk("bready", bready, wr && aw_n > 0 && w_n > 0 && b_n == 0);
         chk("rready", rready, !wr && ar_n > 0 && r_n == 0);
         if (awvalid && awready) aw_n++;
         if (wvalid && wready) w_n++;
         if (arvalid && arready) begin ar_n++; ar_c = c; end
         if (bvalid && bready) b_n++;
         if (rvalid && rready) r_n++;
         if (mem_ready) begin
            lat = c; done = 1;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("mem_rdata", mem_rdata, e[31:0]);
               chk("mem_error", mem_error, e[32]);
            end else chk("sb_empty", sb.size(), 1);
            if (tmo) chk("tmo_arvalid", arvalid, 0);
         end
         @(posedge aclk); #1;
      end
      chk("ready_seen", done, 1);
      if (done) begin
         if (exp_lat > 0) chk("latency", lat, exp_lat);
         chk("ready_pulse", mem_ready, 0);
      end
      chk("aw_beats", aw_n, wr);
      chk("w_beats", w_n, wr);
      chk("b_beats", b_n, wr);
      chk("ar_beats", ar_n, !wr && !tmo);
      chk("r_beats", r_n, !wr && !tmo);
      idle_slave();
   endtask

   initial begin
      areset = 1; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
      idle_slave();
      repeat (2) @(posedge aclk);
      #1;
      chk("reset_mem_ready", mem_ready, 0);
      chk("reset_awvalid", awvalid, 0);
      chk("reset_wvalid", wvalid, 0);
      chk("reset_arvalid", arvalid, 0);
      chk("reset_bready", bready, 0);
      chk("reset_rready", rready, 0);
      chk("reset_rdata", mem_rdata, 0);
      chk("reset_error", mem_error, 0);
      chk("reset_awaddr", awaddr, 0);
      areset = 0;
      @(posedge aclk); #1;

      // zero-wait write
      xfer(1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, 3, 0, 0);
      // skewed readies: AW one cycle late, W three cycles late
      xfer(1, 32'h104, 32'hCAFE_F00D, 4'h3, 1, 3, 0, 0, 2'b00, 32'h0, 0, 6, 0, 0);
      // read with bvalid stuck high and two R wait cycles
      xfer(0, 32'h204, 32'h0, 4'h0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 1, 5, 0, 0);
      // SLVERR write, DECERR read at an unaligned address
      xfer(1, 32'h10, 32'h0000_00AA, 4'h8, 0, 0, 0, 0, 2'b10, 32'h0, 0, 3, 0, 0);
      xfer(0, 32'h301, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 32'h0000_A5A5, 0, 3, 0, 0);
      // reset while waiting in WAIT_R, then a clean read
      xfer(0, 32'h208, 32'h0, 4'h0, 0, 0, 0, 10, 2'b00, 32'h7777_7777, 0, 0, 0, 3);
      chk("post_rst_ready", mem_ready, 0);
      xfer(0, 32'h400, 32'h0, 4'h0, 0, 0, 1, 0, 2'b00, 32'h0000_55AA, 0, 4, 0, 0);
`ifdef AXIL_TIMEOUT_EN
      // slave never accepts AR
      xfer(0, 32'h500, 32'h0, 4'h0, 0, 0, 1000, 0, 2'b00, 32'h0, 0, 8, 1, 0);
`endif
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
